// File: rtl/fifo_pkg.sv
// Shared helpers for the async FIFO read-side blocks: derived widths and the
// statistics counter type.
package fifo_pkg;

  typedef logic [31:0] stat_cnt_t;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int occ_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int ratio_of(input int bits, input int out_bits);
    return bits / out_bits;
  endfunction

  function automatic int idx_w(input int ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

endpackage

// File: rtl/fifo_rd_word_buf.sv
// Circular DEPTH x BITS word buffer with occupancy count; head_data shows the
// oldest word whenever occ != 0.
module fifo_rd_word_buf
  import fifo_pkg::*;
#(
  parameter int BITS  = 32,
  parameter int DEPTH = 2,
  localparam int PW   = ptr_w(DEPTH),
  localparam int OW   = occ_w(DEPTH)
) (
  input  logic            rd_clk,
  input  logic            rd_rst_n,
  input  logic            push,
  input  logic [BITS-1:0] push_data,
  input  logic            pop,
  output logic [BITS-1:0] head_data,
  output logic [OW-1:0]   occ
);

  logic [BITS-1:0] mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Storage carries no reset; only pointers and occupancy are control state.
  always_ff @(posedge rd_clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  assign head_data = mem[rd_ptr];

  push_never_full: assert property (@(posedge rd_clk) disable iff (!rd_rst_n)
    push |-> (occ != OW'(DEPTH)));

endmodule

// File: rtl/fifo_rd_unpacker.sv
// Async FIFO read-side consumer: issues reads, captures words, and streams them
// out LSB slice first. Define FIFO_RD_UNPACK_STATS_EN for word/stall counters.
module fifo_rd_unpacker
  import fifo_pkg::*;
#(
  parameter int BITS      = 32,
  parameter int OUT_BITS  = 8,
  parameter int BUF_DEPTH = 2
) (
  input  logic                rd_clk,
  input  logic                rd_rst_n,
  output logic                fifo_rd_en,
  input  logic [BITS-1:0]     fifo_rd_data,
  input  logic                fifo_rd_empty,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [OUT_BITS-1:0] m_data,
  output logic                m_first,
  output logic                m_last
`ifdef FIFO_RD_UNPACK_STATS_EN
  ,
  output stat_cnt_t           stat_words,
  output stat_cnt_t           stat_stall
`endif
);

  localparam int RATIO = ratio_of(BITS, OUT_BITS);
  localparam int IW    = idx_w(RATIO);
  localparam int OW    = occ_w(BUF_DEPTH);
  localparam int LW    = OW + 1;

  if ((BITS % OUT_BITS) != 0 || BUF_DEPTH < 2) begin : g_bad_cfg
    $error("fifo_rd_unpacker: BITS must be a multiple of OUT_BITS and BUF_DEPTH >= 2");
  end

  logic            run;
  logic            rd_vld_p1;
  logic [IW-1:0]   idx;
  logic [OW-1:0]   occ;
  logic [BITS-1:0] head_word;
  logic            hs;
  logic            idx_at_last;
  logic            pop_word;
  logic [LW-1:0]   level_next;

  assign hs          = m_valid && m_ready;
  assign idx_at_last = (idx == IW'(RATIO - 1));
  assign pop_word    = hs && idx_at_last;

  // Issue stage: the read is allowed only if the word it returns has a slot.
  always_comb begin
    level_next = LW'(occ) + LW'(rd_vld_p1) - LW'(pop_word);
    fifo_rd_en = run && !fifo_rd_empty && (level_next < LW'(BUF_DEPTH));
  end

  // Capture stage: FIFO data is valid one cycle after an accepted read.
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      run       <= 1'b0;
      rd_vld_p1 <= 1'b0;
      idx       <= '0;
    end else begin
      run       <= 1'b1;
      rd_vld_p1 <= fifo_rd_en;
      if (hs) idx <= idx_at_last ? '0 : idx + 1'b1;
    end
  end

  fifo_rd_word_buf #(
    .BITS  (BITS),
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .rd_clk    (rd_clk),
    .rd_rst_n  (rd_rst_n),
    .push      (rd_vld_p1),
    .push_data (fifo_rd_data),
    .pop       (pop_word),
    .head_data (head_word),
    .occ       (occ)
  );

  // Output stage: slices come straight off the head word, zero while idle.
  assign m_valid = (occ != '0);
  assign m_data  = m_valid ? head_word[idx*OUT_BITS +: OUT_BITS] : '0;
  assign m_first = m_valid && (idx == '0);
  assign m_last  = m_valid && idx_at_last;

`ifdef FIFO_RD_UNPACK_STATS_EN
  function automatic stat_cnt_t sat_inc(input stat_cnt_t c);
    return (c == '1) ? c : c + 1'b1;
  endfunction

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      stat_words <= '0;
      stat_stall <= '0;
    end else begin
      if (pop_word)            stat_words <= sat_inc(stat_words);
      if (m_valid && !m_ready) stat_stall <= sat_inc(stat_stall);
    end
  end
`endif

endmodule

// File: tb/tb_fifo_rd_unpacker.sv
// Bench for fifo_rd_unpacker: a queue-based FIFO model feeds two instances
// (8-bit slices and full-width words) and a byte scoreboard checks the stream.
module tb_fifo_rd_unpacker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Instance A: 32 -> 8 bit slices
  logic        rd_en_a;
  logic [31:0] rd_data_a = '0;
  logic        empty_a = 1'b1;
  logic        m_valid_a, m_ready_a = 1'b0, m_first_a, m_last_a;
  logic [7:0]  m_data_a;
  logic [31:0] q_a[$];

  // Instance B: full-width words
  logic        rd_en_b;
  logic [31:0] rd_data_b = '0;
  logic        empty_b = 1'b1;
  logic        m_valid_b, m_ready_b = 1'b1, m_first_b, m_last_b;
  logic [31:0] m_data_b;
  logic [31:0] q_b[$];

`ifdef FIFO_RD_UNPACK_STATS_EN
  logic [31:0] stat_words_a, stat_stall_a, stat_words_b, stat_stall_b;
`endif

  fifo_rd_unpacker #(.BITS(32), .OUT_BITS(8), .BUF_DEPTH(2)) dut_a (
    .rd_clk(clk), .rd_rst_n(rst_n), .fifo_rd_en(rd_en_a), .fifo_rd_data(rd_data_a),
    .fifo_rd_empty(empty_a), .m_valid(m_valid_a), .m_ready(m_ready_a),
    .m_data(m_data_a), .m_first(m_first_a), .m_last(m_last_a)
`ifdef FIFO_RD_UNPACK_STATS_EN
    , .stat_words(stat_words_a), .stat_stall(stat_stall_a)
`endif
  );

  fifo_rd_unpacker #(.BITS(32), .OUT_BITS(32), .BUF_DEPTH(2)) dut_b (
    .rd_clk(clk), .rd_rst_n(rst_n), .fifo_rd_en(rd_en_b), .fifo_rd_data(rd_data_b),
    .fifo_rd_empty(empty_b), .m_valid(m_valid_b), .m_ready(m_ready_b),
    .m_data(m_data_b), .m_first(m_first_b), .m_last(m_last_b)
`ifdef FIFO_RD_UNPACK_STATS_EN
    , .stat_words(stat_words_b), .stat_stall(stat_stall_b)
`endif
  );

  // FIFO models: registered read data, empty flag follows queue contents.
  always @(posedge clk) begin
    if (rd_en_a && q_a.size() > 0) begin
      rd_data_a <= q_a.pop_front();
      empty_a   <= (q_a.size() == 0);
    end
    if (rd_en_b && q_b.size() > 0) begin
      rd_data_b <= q_b.pop_front();
      empty_b   <= (q_b.size() == 0);
    end
  end

  task automatic push_a(input logic [31:0] w);
    q_a.push_back(w);
    empty_a = 1'b0;
  endtask

  task automatic push_b(input logic [31:0] w);
    q_b.push_back(w);
    empty_b = 1'b0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  typedef struct {
    logic [31:0] word;
    logic [7:0]  s0, s1, s2, s3;
  } vec_t;

  vec_t tbl[5];

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  exp_s[4];
    logic [31:0] words[8];
    logic [31:0] w32[10];
    logic [7:0]  exp_q[$];
    logic [7:0]  prev_data;
    logic [31:0] w, next_word;
    logic        prev_stall;
    int          pulses, s, got, sent, stalls, cyc;
    bit          seen;

    tbl[0] = '{32'hDDCCBBAA, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    tbl[1] = '{32'h12345678, 8'h78, 8'h56, 8'h34, 8'h12};
    tbl[2] = '{32'h00000000, 8'h00, 8'h00, 8'h00, 8'h00};
    tbl[3] = '{32'hFFFFFFFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    tbl[4] = '{32'h80010203, 8'h03, 8'h02, 8'h01, 8'h80};

    // Reset held with a non-empty FIFO: everything stays quiet.
    @(negedge clk);
    push_a(32'h11111111); push_a(32'h22222222); push_a(32'h33333333);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      chk("rst_rd_en", rd_en_a, 0);
      chk("rst_valid", m_valid_a, 0);
      chk("rst_data", m_data_a, 0);
      chk("rst_first", m_first_a, 0);
      chk("rst_last", m_last_a, 0);
    end
    q_a.delete(); empty_a = 1'b1;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    // Table: single words with m_ready high.
    for (int t = 0; t < 5; t++) begin
      exp_s = '{tbl[t].s0, tbl[t].s1, tbl[t].s2, tbl[t].s3};
      @(negedge clk);
      push_a(tbl[t].word);
      m_ready_a = 1'b1;
      pulses = 0; s = 0;
      for (int c = 0; c < 8; c++) begin
        if (c > 0) @(negedge clk);
        #1;
        if (rd_en_a) pulses++;
        if (m_valid_a) begin
          if (s < 4) begin
            chk("tbl_data", m_data_a, exp_s[s]);
            chk("tbl_first", m_first_a, (s == 0));
            chk("tbl_last", m_last_a, (s == 3));
          end
          s++;
        end
      end
      chk("tbl_slices", s, 4);
      chk("tbl_rd_pulses", pulses, 1);
    end

    // Backpressure: 8 words queued, m_ready low, then drain.
    @(negedge clk);
    m_ready_a = 1'b0;
    for (int k = 0; k < 8; k++) begin
      words[k] = 32'hDDCCBBAA + 32'h04040404 * k;
      push_a(words[k]);
    end
    pulses = 0;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (rd_en_a) pulses++;
      if (c >= 2) begin
        chk("bp_valid", m_valid_a, 1);
        chk("bp_data_hold", m_data_a, 8'hAA);
      end
    end
    chk("bp_rd_pulses", pulses, 2);
    got = 0;
    for (int c = 0; c < 200 && got < 32; c++) begin
      @(negedge clk);
      m_ready_a = 1'b1;
      #1;
      if (m_valid_a) begin
        chk("bp_drain_data", m_data_a, words[got/4][8*(got%4) +: 8]);
        got++;
      end
    end
    chk("bp_drain_count", got, 32);

    // Full-width instance: one word per cycle, no bubbles.
    @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      w32[k] = $urandom;
      push_b(w32[k]);
    end
    for (int c = 0; c < 12; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      chk("thr_rd_en", rd_en_b, (c < 10));
      chk("thr_valid", m_valid_b, (c >= 2));
      if (c >= 2) begin
        chk("thr_data", m_data_b, w32[c-2]);
        chk("thr_first_last", {m_first_b, m_last_b}, 2'b11);
      end
    end

    // Random traffic against a byte scoreboard.
    m_ready_a = 1'b0;
    do_reset();
    got = 0; sent = 0; stalls = 0; prev_stall = 1'b0; prev_data = '0;
    for (cyc = 0; cyc < 6000 && got < 400; cyc++) begin
      @(negedge clk);
      if (sent < 100 && $urandom_range(0, 2) != 0) begin
        w = $urandom;
        push_a(w);
        for (int b = 0; b < 4; b++) exp_q.push_back(w[8*b +: 8]);
        sent++;
      end
      m_ready_a = 1'($urandom_range(0, 1));
      #1;
      if (prev_stall) begin
        chk("rnd_hold_valid", m_valid_a, 1);
        chk("rnd_hold_data", m_data_a, prev_data);
      end
      if (m_valid_a && m_ready_a) begin
        if (exp_q.size() == 0) begin
          chk("rnd_extra_slice", 1, 0);
        end else begin
          chk("rnd_data", m_data_a, exp_q.pop_front());
        end
        chk("rnd_first", m_first_a, (got % 4 == 0));
        chk("rnd_last", m_last_a, (got % 4 == 3));
        got++;
      end
      if (m_valid_a && !m_ready_a) stalls++;
      prev_stall = m_valid_a && !m_ready_a;
      prev_data  = m_data_a;
    end
    chk("rnd_slice_count", got, 400);
    @(negedge clk); #1;
    chk("rnd_idle", m_valid_a, 0);
`ifdef FIFO_RD_UNPACK_STATS_EN
    chk("stat_words", stat_words_a, 100);
    chk("stat_stall", stat_stall_a, stalls);
`endif

    // Reset in the middle of a word (slice index 2 showing).
    @(negedge clk);
    m_ready_a = 1'b1;
    push_a(32'hA3A2A1A0); push_a(32'hB3B2B1B0); push_a(32'hC3C2C1C0);
    got = 0; seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (m_valid_a && got == 2) begin
        seen = 1'b1;
        break;
      end
      if (m_valid_a && m_ready_a) got++;
    end
    chk("mid_reached_idx2", seen, 1);
    chk("mid_slice2", m_data_a, 8'hA2);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", m_valid_a, 0);
    chk("mid_rst_data", m_data_a, 0);
    @(negedge clk); #1;
    chk("mid_rst_valid_hold", m_valid_a, 0);
    chk("mid_rst_rd_en", rd_en_a, 0);
    next_word = (q_a.size() > 0) ? q_a[0] : 32'hDEADBEEF;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk); #1;
      if (m_valid_a) begin
        seen = 1'b1;
        chk("mid_after_data", m_data_a, next_word[7:0]);
        chk("mid_after_first", m_first_a, 1);
      end
    end
    chk("mid_after_seen", seen, 1);
    for (int c = 0; c < 20; c++) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
